// File: rtl/root_5_multi_cycle_if.sv
// Argument/result handshake for the iterative fifth-root unit.
// The unit sits on the slave side; whoever supplies arguments is the master.
interface root_5_multi_cycle_if #(
  parameter int w = 8
);
  localparam int r = (w + 4) / 5;

  logic         arg_vld;
  logic         arg_rdy;
  logic [w-1:0] arg;
  logic         res_vld;
  logic [r-1:0] res;

  modport master (output arg_vld, arg, input arg_rdy, res_vld, res);
  modport slave  (input arg_vld, arg, output arg_rdy, res_vld, res);
endinterface

// File: rtl/root_5_multi_cycle.sv
// Iterative unsigned fifth root: res = floor(arg^(1/5)), one root bit per
// pass, each pass raising the candidate to the fifth power on one multiplier.
module root_5_multi_cycle #(
  parameter int w = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  root_5_multi_cycle_if.slave  bus
);
  localparam int r  = (w + 4) / 5;
  localparam int aw = 5 * r;
  localparam int iw = (r > 1) ? $clog2(r) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] CMP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [iw-1:0] I_TOP   = iw'(r - 1);
  localparam logic [r-1:0]  TOP_BIT = r'(1) << (r - 1);

  function automatic logic [r-1:0] bit_at(input logic [iw-1:0] idx);
    return r'(1) << idx;
  endfunction

  logic [1:0]    state;
  logic [1:0]    mcnt;
  logic [iw-1:0] i;
  logic [w-1:0]  arg_q;
  logic [r-1:0]  root;
  logic [r-1:0]  cand;
  logic [aw-1:0] acc;

  logic [aw-1:0] prod;
  logic [aw-1:0] arg_ext;
  logic          fits;
  logic [r-1:0]  root_upd;
  logic [iw-1:0] i_dn;
  logic [r-1:0]  cand_nxt;

  // acc never exceeds cand^5 < 2^(5r), so truncating the product is exact
  assign prod     = acc * aw'(cand);
  assign arg_ext  = aw'(arg_q);
  assign fits     = (acc <= arg_ext);
  assign root_upd = fits ? (root | bit_at(i)) : root;
  assign i_dn     = i - iw'(1);
  assign cand_nxt = root_upd | bit_at(i_dn);

  assign bus.arg_rdy = (state == IDLE);

  // Control: sequencing, bit index, multiply count and the result port
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mcnt        <= 2'd0;
      i           <= I_TOP;
      bus.res_vld <= 1'b0;
      bus.res     <= '0;
    end else begin
      bus.res_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.arg_vld) begin
            i     <= I_TOP;
            mcnt  <= 2'd0;
            state <= MUL;
          end
        end
        MUL: begin
          mcnt <= mcnt + 2'd1;
          if (mcnt == 2'd3) state <= CMP;
        end
        CMP: begin
          if (i == '0) begin
            // result register loads on entry to DONE so it is current while res_vld is high
            bus.res     <= root_upd;
            bus.res_vld <= 1'b1;
            state       <= DONE;
          end else begin
            i     <= i_dn;
            mcnt  <= 2'd0;
            state <= MUL;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: latched argument, partial root, candidate and power accumulator
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (bus.arg_vld) begin
          arg_q <= bus.arg;
          root  <= '0;
          cand  <= TOP_BIT;
          acc   <= aw'(TOP_BIT);
        end
      end
      MUL: acc <= prod;
      CMP: begin
        root <= root_upd;
        if (i != '0) begin
          cand <= cand_nxt;
          acc  <= aw'(cand_nxt);
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_root_5_multi_cycle.sv
// Bench for the fifth-root unit: directed vector table at w=8 and w=16 plus
// hand-written streaming, reset and exhaustive w=8 sequences.
module tb_root_5_multi_cycle;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  root_5_multi_cycle_if #(.w(8))  b8 ();
  root_5_multi_cycle_if #(.w(16)) b16 ();

  root_5_multi_cycle #(.w(8))  u8  (.clk(clk), .rst(rst), .bus(b8.slave));
  root_5_multi_cycle #(.w(16)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          wsel;
    logic [15:0] a;
    logic [3:0]  exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int root5(input int a);
    int x = 0;
    while ((x + 1) ** 5 <= a) x++;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one argument to an idle unit, then counts cycles until res_vld.
  task automatic run_job(input int wsel, input logic [15:0] a,
                         output logic [3:0] got, output int lat, output int rdy_low);
    logic v, rd;
    logic [3:0] rs;
    got = '0; lat = 0; rdy_low = 0;
    if (wsel == 8) begin b8.arg = a[7:0]; b8.arg_vld = 1'b1; end
    else begin b16.arg = a; b16.arg_vld = 1'b1; end
    tick();
    b8.arg_vld = 1'b0;
    b16.arg_vld = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      v  = (wsel == 8) ? b8.res_vld : b16.res_vld;
      rd = (wsel == 8) ? b8.arg_rdy : b16.arg_rdy;
      rs = (wsel == 8) ? {2'b00, b8.res} : b16.res;
      if (!rd) rdy_low++;
      if (v) begin
        lat = c;
        got = rs;
        break;
      end
      tick();
    end
  endtask

  logic [3:0] got;
  int lat, rdy_low, seen, last_acc, nres;
  int q_arg[$];
  int q_cyc[$];

  initial begin
    vecs[0]  = '{8, 16'd0,     4'd0, 11};
    vecs[1]  = '{8, 16'd1,     4'd1, 11};
    vecs[2]  = '{8, 16'd31,    4'd1, 11};
    vecs[3]  = '{8, 16'd32,    4'd2, 11};
    vecs[4]  = '{8, 16'd242,   4'd2, 11};
    vecs[5]  = '{8, 16'd243,   4'd3, 11};
    vecs[6]  = '{8, 16'd255,   4'd3, 11};
    vecs[7]  = '{16, 16'd59048, 4'd8, 21};
    vecs[8]  = '{16, 16'd59049, 4'd9, 21};
    vecs[9]  = '{16, 16'd65535, 4'd9, 21};
    vecs[10] = '{16, 16'd1024,  4'd4, 21};
    vecs[11] = '{16, 16'd1023,  4'd3, 21};

    rst = 1'b1;
    b8.arg_vld = 1'b0;  b8.arg = '0;
    b16.arg_vld = 1'b0; b16.arg = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_res_vld", b8.res_vld, 0);
    check("reset_res", b8.res, 0);
    check("reset_arg_rdy", b8.arg_rdy, 1);
    check("reset_arg_rdy16", b16.arg_rdy, 1);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (b8.res_vld || b16.res_vld) seen = 1;
      tick();
    end
    check("idle_no_res_vld", seen, 0);

    // Directed table at both widths
    foreach (vecs[n]) begin
      run_job(vecs[n].wsel, vecs[n].a, got, lat, rdy_low);
      check($sformatf("vec%0d_res", n), got, vecs[n].exp_res);
      check($sformatf("vec%0d_lat", n), lat, vecs[n].exp_lat);
      check($sformatf("vec%0d_rdy_low", n), rdy_low, vecs[n].exp_lat);
      tick();
      check($sformatf("vec%0d_pulse_end", n),
            (vecs[n].wsel == 8) ? b8.res_vld : b16.res_vld, 0);
    end

    // arg_vld held high with arg changing every cycle
    last_acc = -1;
    nres = 0;
    b8.arg_vld = 1'b1;
    for (int c = 0; c < 62; c++) begin
      b8.arg = 8'(c * 37 + 11);
      if (b8.res_vld) begin
        if (q_arg.size() == 0) begin
          check("stream_unexpected_res", 1, 0);
        end else begin
          check($sformatf("stream_res_arg%0d", q_arg[0]), b8.res, root5(q_arg[0]));
          check("stream_lat", c - q_cyc[0], 11);
          void'(q_arg.pop_front());
          void'(q_cyc.pop_front());
          nres++;
        end
      end
      if (b8.arg_rdy) begin
        if (last_acc >= 0) check("stream_period", c - last_acc, 12);
        last_acc = c;
        q_arg.push_back(int'(b8.arg));
        q_cyc.push_back(c);
      end
      tick();
    end
    b8.arg_vld = 1'b0;
    check("stream_count", nres, 5);
    for (int k = 0; k < 20; k++) begin
      if (b8.arg_rdy) break;
      tick();
    end
    check("stream_drain_idle", b8.arg_rdy, 1);

    // Reset and arg_vld together: nothing is accepted
    b8.arg = 8'd200;
    b8.arg_vld = 1'b1;
    rst = 1'b1;
    tick();
    b8.arg_vld = 1'b0;
    rst = 1'b0;
    check("rst_vld_not_accepted", b8.arg_rdy, 1);

    // Reset in the middle of a job
    run_job(8, 16'd255, got, lat, rdy_low);
    check("pre_rst_res", got, 3);
    tick();
    b8.arg = 8'd243;
    b8.arg_vld = 1'b1;
    tick();
    b8.arg_vld = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_arg_rdy", b8.arg_rdy, 1);
    check("midrst_res_vld", b8.res_vld, 0);
    check("midrst_res", b8.res, 0);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (b8.res_vld) seen = 1;
      tick();
    end
    check("midrst_no_emit", seen, 0);
    run_job(8, 16'd32, got, lat, rdy_low);
    check("after_rst_res", got, 2);
    check("after_rst_lat", lat, 11);
    tick();

    // Exhaustive w=8 against the root bounds
    for (int a = 0; a < 256; a++) begin
      run_job(8, 16'(a), got, lat, rdy_low);
      check($sformatf("exh_bounds_a%0d", a),
            ((int'(got) ** 5 <= a) && ((int'(got) + 1) ** 5 > a)) ? 1 : 0, 1);
      check($sformatf("exh_lat_a%0d", a), lat, 11);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
